// File: rtl/rtu_rob_queue.sv
// RTU reorder buffer: in-order allocate, out-of-order complete,
// two-wide in-order retire with registered redirect pulse.
module rtu_rob_queue #(
  parameter int DEPTH  = 16,
  parameter int IID_W  = $clog2(DEPTH),
  parameter int PC_W   = 64,
  parameter int PDST_W = 6
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              create_vld,
  input  logic [PC_W-1:0]   create_pc,
  input  logic              create_dst_vld,
  input  logic [PDST_W-1:0] create_pdst,
  output logic              create_rdy,
  output logic [IID_W-1:0]  create_iid,
  input  logic              cmpl0_vld,
  input  logic [IID_W-1:0]  cmpl0_iid,
  input  logic              cmpl0_jump,
  input  logic              cmpl1_vld,
  input  logic [IID_W-1:0]  cmpl1_iid,
  input  logic              rtu_global_flush,
  output logic              retire0_vld,
  output logic              retire1_vld,
  output logic [PDST_W-1:0] retire0_pdst,
  output logic [PDST_W-1:0] retire1_pdst,
  output logic              retire0_dst_vld,
  output logic              retire1_dst_vld,
  output logic              flush_vld,
  output logic              jump_vld,
  output logic [PC_W-1:0]   flush_pc,
  output logic              rob_empty,
  output logic [IID_W:0]    entry_cnt
);

  logic [IID_W-1:0]  head_q;
  logic [IID_W-1:0]  tail_q;
  logic [IID_W-1:0]  head1;
  logic [IID_W:0]    count_q;
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  cmpl_q;
  logic [DEPTH-1:0]  jmp_q;
  logic [DEPTH-1:0]  dvld_q;
  logic [PC_W-1:0]   pc_q [DEPTH];
  logic [PDST_W-1:0] pdst_q [DEPTH];
  logic              flush_q;
  logic [PC_W-1:0]   fpc_q;

  logic [DEPTH-1:0]  hit0;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  jset;
  logic [DEPTH-1:0]  eff_c;
  logic [DEPTH-1:0]  eff_j;
  logic [DEPTH-1:0]  vld_clr;
  logic [DEPTH-1:0]  vld_set;
  logic              blk;
  logic              ret0;
  logic              ret1;
  logic              redir;
  logic              fire;
  logic [1:0]        nret;

  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0[i] = cmpl0_vld & (cmpl0_iid == IID_W'(i));
      hit1[i] = cmpl1_vld & (cmpl1_iid == IID_W'(i));
    end
  end

  // same-cycle completion bypasses the stored flags
  assign jset  = hit0 & {DEPTH{cmpl0_jump}};
  assign eff_c = cmpl_q | hit0 | hit1;
  assign eff_j = jmp_q | jset;

  assign head1 = head_q + IID_W'(1);
  assign blk   = flush_q | rtu_global_flush;
  assign ret0  = vld_q[head_q] & eff_c[head_q] & ~blk;
  assign ret1  = ret0 & vld_q[head1] & eff_c[head1]
               & ~eff_j[head_q];
  assign redir = ret0 & eff_j[head_q];
  assign nret  = {1'b0, ret0} + {1'b0, ret1};

  assign create_rdy = (count_q != (IID_W+1)'(DEPTH)) & ~blk;
  assign fire       = create_vld & create_rdy;

  assign vld_clr = ({DEPTH{ret0}} & (DEPTH'(1) << head_q))
                 | ({DEPTH{ret1}} & (DEPTH'(1) << head1));
  assign vld_set = {DEPTH{fire}} & (DEPTH'(1) << tail_q);

  assign create_iid      = tail_q;
  assign retire0_vld     = ret0;
  assign retire1_vld     = ret1;
  assign retire0_pdst    = ret0 ? pdst_q[head_q] : '0;
  assign retire1_pdst    = ret1 ? pdst_q[head1] : '0;
  assign retire0_dst_vld = ret0 & dvld_q[head_q];
  assign retire1_dst_vld = ret1 & dvld_q[head1];
  assign flush_vld       = flush_q;
  assign jump_vld        = flush_q;
  assign flush_pc        = fpc_q;
  assign rob_empty       = (count_q == '0);
  assign entry_cnt       = count_q;

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      cmpl_q  <= '0;
      jmp_q   <= '0;
      dvld_q  <= '0;
      flush_q <= 1'b0;
      fpc_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pdst_q[i] <= '0;
      end
    end else begin
      flush_q <= redir;
      if (redir) fpc_q <= pc_q[head_q];
      if (blk) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        vld_q   <= '0;
        cmpl_q  <= '0;
        jmp_q   <= '0;
      end else begin
        head_q  <= head_q + IID_W'(nret);
        tail_q  <= tail_q + IID_W'(fire);
        count_q <= count_q + (IID_W+1)'(fire)
                 - (IID_W+1)'(nret);
        vld_q   <= (vld_q & ~vld_clr) | vld_set;
        cmpl_q  <= (cmpl_q | ((hit0 | hit1) & vld_q))
                 & ~vld_set;
        jmp_q   <= (jmp_q | (jset & vld_q)) & ~vld_set;
        if (fire) begin
          pc_q[tail_q]   <= create_pc;
          dvld_q[tail_q] <= create_dst_vld;
          pdst_q[tail_q] <= create_dst_vld ? create_pdst : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtu_rob_queue.sv
// Bench for rtu_rob_queue: vector table, directed corner
// sequences and random traffic against a queue model.
module tb_rtu_rob_queue;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_clk = 1'b1;
  logic        create_vld = 1'b0;
  logic [63:0] create_pc = '0;
  logic        create_dst_vld = 1'b0;
  logic [5:0]  create_pdst = '0;
  logic        create_rdy;
  logic [3:0]  create_iid;
  logic        cmpl0_vld = 1'b0;
  logic [3:0]  cmpl0_iid = '0;
  logic        cmpl0_jump = 1'b0;
  logic        cmpl1_vld = 1'b0;
  logic [3:0]  cmpl1_iid = '0;
  logic        rtu_global_flush = 1'b0;
  logic        retire0_vld, retire1_vld;
  logic [5:0]  retire0_pdst, retire1_pdst;
  logic        retire0_dst_vld, retire1_dst_vld;
  logic        flush_vld, jump_vld;
  logic [63:0] flush_pc;
  logic        rob_empty;
  logic [4:0]  entry_cnt;

  rtu_rob_queue dut (
    .clk(clk), .rst_clk(rst_clk),
    .create_vld(create_vld), .create_pc(create_pc),
    .create_dst_vld(create_dst_vld),
    .create_pdst(create_pdst),
    .create_rdy(create_rdy), .create_iid(create_iid),
    .cmpl0_vld(cmpl0_vld), .cmpl0_iid(cmpl0_iid),
    .cmpl0_jump(cmpl0_jump),
    .cmpl1_vld(cmpl1_vld), .cmpl1_iid(cmpl1_iid),
    .rtu_global_flush(rtu_global_flush),
    .retire0_vld(retire0_vld), .retire1_vld(retire1_vld),
    .retire0_pdst(retire0_pdst), .retire1_pdst(retire1_pdst),
    .retire0_dst_vld(retire0_dst_vld),
    .retire1_dst_vld(retire1_dst_vld),
    .flush_vld(flush_vld), .jump_vld(jump_vld),
    .flush_pc(flush_pc), .rob_empty(rob_empty),
    .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cv;
    logic [63:0] pc;
    bit          dv;
    logic [5:0]  pdst;
    bit          c0v;
    logic [3:0]  c0i;
    bit          c0j;
    bit          c1v;
    logic [3:0]  c1i;
    bit          gf;
  } in_t;

  typedef struct {
    in_t        in;
    bit         r0;
    bit         r1;
    logic [5:0] p0;
    logic [5:0] p1;
    logic [4:0] cnt;
  } tv_t;

  typedef struct {
    logic [63:0] pc;
    bit          dv;
    logic [5:0]  pdst;
    int          iid;
    bit          c;
    bit          j;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: program-ordered list of live entries
  ent_t        mq[$];
  int          m_tail;
  bit          m_fl;
  logic [63:0] m_fpc;
  in_t         cur;
  bit          e_rdy, e_r0, e_r1, e_j0;

  tv_t tv[8];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", n, a, e, $time);
    end
  endtask

  function automatic in_t idle();
    in_t r = '{default: '0};
    return r;
  endfunction

  function automatic in_t cr(logic [63:0] pc, logic [5:0] p);
    in_t r = idle();
    r.cv = 1; r.pc = pc; r.dv = 1; r.pdst = p;
    return r;
  endfunction

  function automatic in_t c0(int iid, bit j);
    in_t r = idle();
    r.c0v = 1; r.c0i = 4'(iid); r.c0j = j;
    return r;
  endfunction

  function automatic in_t c01(int a, int b);
    in_t r = idle();
    r.c0v = 1; r.c0i = 4'(a);
    r.c1v = 1; r.c1i = 4'(b);
    return r;
  endfunction

  function automatic bit eff_c(int k);
    return mq[k].c
      || (cur.c0v && cur.c0i == 4'(mq[k].iid))
      || (cur.c1v && cur.c1i == 4'(mq[k].iid));
  endfunction

  function automatic bit eff_j(int k);
    return mq[k].j
      || (cur.c0v && cur.c0j && cur.c0i == 4'(mq[k].iid));
  endfunction

  task automatic drive(input in_t x);
    cur = x;
    create_vld = x.cv;
    create_pc = x.pc;
    create_dst_vld = x.dv;
    create_pdst = x.pdst;
    cmpl0_vld = x.c0v;
    cmpl0_iid = x.c0i;
    cmpl0_jump = x.c0j;
    cmpl1_vld = x.c1v;
    cmpl1_iid = x.c1i;
    rtu_global_flush = x.gf;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_fl = 0;
    m_fpc = '0;
  endtask

  task automatic apply(input in_t x);
    bit blk;
    logic [5:0] ep;
    logic ed;
    @(negedge clk);
    drive(x);
    #1;
    blk = m_fl || x.gf;
    e_rdy = (mq.size() != D) && !blk;
    e_r0 = !blk && mq.size() > 0 && eff_c(0);
    e_j0 = mq.size() > 0 && eff_j(0);
    e_r1 = e_r0 && mq.size() > 1 && eff_c(1) && !e_j0;
    chk("create_rdy", create_rdy, e_rdy);
    chk("create_iid", create_iid, m_tail);
    chk("entry_cnt", entry_cnt, mq.size());
    chk("rob_empty", rob_empty, mq.size() == 0);
    chk("retire0_vld", retire0_vld, e_r0);
    chk("retire1_vld", retire1_vld, e_r1);
    chk("flush_vld", flush_vld, m_fl);
    chk("jump_vld", jump_vld, m_fl);
    if (m_fl) chk("flush_pc", flush_pc, m_fpc);
    if (e_r0 || x.gf) begin
      ep = '0; ed = 0;
      if (e_r0) begin ep = mq[0].pdst; ed = mq[0].dv; end
      chk("retire0_pdst", retire0_pdst, ep);
      chk("retire0_dst_vld", retire0_dst_vld, ed);
    end
    if (e_r1 || x.gf) begin
      ep = '0; ed = 0;
      if (e_r1) begin ep = mq[1].pdst; ed = mq[1].dv; end
      chk("retire1_pdst", retire1_pdst, ep);
      chk("retire1_dst_vld", retire1_dst_vld, ed);
    end
  endtask

  task automatic commit();
    bit nf;
    ent_t e;
    @(posedge clk);
    if (cur.gf || m_fl) begin
      mq.delete();
      m_tail = 0;
      m_fl = 0;
    end else begin
      nf = e_r0 && e_j0;
      if (nf) m_fpc = mq[0].pc;
      foreach (mq[k]) begin
        if (cur.c0v && cur.c0i == 4'(mq[k].iid)) begin
          mq[k].c = 1;
          if (cur.c0j) mq[k].j = 1;
        end
        if (cur.c1v && cur.c1i == 4'(mq[k].iid)) mq[k].c = 1;
      end
      if (e_r0) void'(mq.pop_front());
      if (e_r1) void'(mq.pop_front());
      if (cur.cv && e_rdy) begin
        e.pc = cur.pc; e.dv = cur.dv;
        e.pdst = cur.dv ? cur.pdst : 6'd0;
        e.iid = m_tail; e.c = 0; e.j = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % D;
      end
      m_fl = nf;
    end
  endtask

  task automatic step(input in_t x);
    apply(x);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle());
    rst_clk = 1;
    #1;
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_entry_cnt", entry_cnt, 0);
    chk("rst_create_rdy", create_rdy, 1);
    #1;
    rst_clk = 0;
    model_reset();
  endtask

  task automatic set_tv(input int i, input in_t x, input bit r0,
                        input bit r1, input logic [5:0] p0,
                        input logic [5:0] p1,
                        input logic [4:0] cnt);
    tv[i].in = x; tv[i].r0 = r0; tv[i].r1 = r1;
    tv[i].p0 = p0; tv[i].p1 = p1; tv[i].cnt = cnt;
  endtask

  initial begin
    in_t x;
    bit slow;
    set_tv(0, cr(64'h100, 6'd10), 0, 0, 0, 0, 0);
    set_tv(1, cr(64'h104, 6'd11), 0, 0, 0, 0, 1);
    set_tv(2, cr(64'h108, 6'd12), 0, 0, 0, 0, 2);
    set_tv(3, c0(2, 0), 0, 0, 0, 0, 3);
    set_tv(4, c0(1, 0), 0, 0, 0, 0, 3);
    set_tv(5, c0(0, 0), 1, 1, 6'd10, 6'd11, 3);
    set_tv(6, idle(), 1, 0, 6'd12, 0, 1);
    set_tv(7, idle(), 0, 0, 0, 0, 0);

    model_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(tv[i].in);
      chk("tv_r0", retire0_vld, tv[i].r0);
      chk("tv_r1", retire1_vld, tv[i].r1);
      chk("tv_cnt", entry_cnt, tv[i].cnt);
      if (tv[i].r0) chk("tv_p0", retire0_pdst, tv[i].p0);
      if (tv[i].r1) chk("tv_p1", retire1_pdst, tv[i].p1);
      commit();
    end
    apply(idle());
    chk("tv_empty", rob_empty, 1);
    commit();

    // fill to full, wrap, no same-cycle credit
    do_reset();
    for (int i = 0; i < D; i++)
      step(cr(64'h200 + 64'(4 * i), 6'(i)));
    apply(cr(64'h999, 6'd63));
    chk("full_rdy", create_rdy, 0);
    chk("full_iid", create_iid, 0);
    chk("full_cnt", entry_cnt, 16);
    commit();
    apply(c01(0, 1));
    chk("full_no_credit", create_rdy, 0);
    chk("full_ret1", retire1_vld, 1);
    commit();
    apply(idle());
    chk("full_rdy_back", create_rdy, 1);
    chk("full_cnt14", entry_cnt, 14);
    commit();

    // redirect from slot0
    do_reset();
    for (int i = 0; i < 4; i++)
      step(cr(64'h300 + 64'(4 * i), 6'(20 + i)));
    step(c0(0, 0));
    x = c01(1, 2);
    x.c0j = 1;
    apply(x);
    chk("jmp_r0", retire0_vld, 1);
    chk("jmp_r0_pdst", retire0_pdst, 21);
    chk("jmp_r1_blocked", retire1_vld, 0);
    commit();
    apply(c0(3, 0));
    chk("jmp_flush", flush_vld, 1);
    chk("jmp_jump", jump_vld, 1);
    chk("jmp_pc", flush_pc, 64'h304);
    chk("jmp_no_ret", retire0_vld, 0);
    commit();
    apply(idle());
    chk("jmp_cnt0", entry_cnt, 0);
    chk("jmp_flush_end", flush_vld, 0);
    commit();

    // dual bypass completion
    do_reset();
    step(cr(64'h400, 6'd30));
    step(cr(64'h404, 6'd31));
    apply(c01(0, 1));
    chk("byp_r0", retire0_vld, 1);
    chk("byp_r1", retire1_vld, 1);
    commit();

    // global flush beats create and retire
    do_reset();
    step(cr(64'h500, 6'd40));
    step(cr(64'h504, 6'd41));
    x = cr(64'h508, 6'd42);
    x.gf = 1; x.c0v = 1; x.c0i = 0;
    apply(x);
    chk("gf_no_ret", retire0_vld, 0);
    chk("gf_no_rdy", create_rdy, 0);
    commit();
    apply(idle());
    chk("gf_cnt", entry_cnt, 0);
    chk("gf_iid", create_iid, 0);
    commit();

    // stale completion to an unallocated iid
    do_reset();
    step(c0(0, 0));
    step(cr(64'h600, 6'd50));
    apply(idle());
    chk("stale_no_ret", retire0_vld, 0);
    commit();
    apply(c0(0, 0));
    chk("stale_ret", retire0_vld, 1);
    commit();

    // random traffic
    do_reset();
    slow = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) slow = ~slow;
      if ($urandom_range(0, 399) == 0) do_reset();
      x = idle();
      x.cv = $urandom_range(0, 3) != 0;
      x.pc = {$urandom, $urandom};
      x.dv = $urandom_range(0, 1) != 0;
      x.pdst = 6'($urandom);
      x.c0v = $urandom_range(0, 99) < (slow ? 15 : 70);
      x.c1v = $urandom_range(0, 99) < (slow ? 15 : 70);
      x.c0i = 4'($urandom);
      x.c1i = 4'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        x.c0i = 4'(mq[$urandom_range(0, mq.size() - 1)].iid);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        x.c1i = 4'(mq[$urandom_range(0, mq.size() - 1)].iid);
      x.c0j = $urandom_range(0, 5) == 0;
      x.gf = $urandom_range(0, 79) == 0;
      step(x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
